// File: rtl/spi_loopback_banked.sv
// Banked SPI self-test responder on the user side of spi_dev_core.
// A command byte per transaction selects write, read-back, echo-loopback or status on one bank.

module ram_sdp #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

module spi_loopback_banked #(
    parameter int AWIDTH = 9,
    parameter int NCHAN  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] user_out,
    input  logic       user_out_stb,
    output logic [7:0] user_in,
    input  logic       user_in_ack,
    input  logic       csn_state,
    input  logic       csn_rise,
    input  logic       csn_fall
);
    localparam int CHW   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int CW    = AWIDTH + 2;
    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [CW-1:0]   CNT_MAX   = '1;
    localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
    localparam logic [AWIDTH:0] LEN_MAX   = (AWIDTH + 1)'(DEPTH);
    localparam logic [CHW-1:0]  BANK_MASK = CHW'(NCHAN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WRITE, S_READ, S_LOOP, S_STAT
    } state_t;

    state_t          state;
    logic [7:0]      cmd_r;
    logic [CHW-1:0]  bank_r;
    logic [CW-1:0]   mosi_cnt;
    logic [CW-1:0]   miso_cnt;
    logic [7:0]      loop_hold;
    logic [7:0]      tx_cnt;
    logic [AWIDTH:0] len_r [NCHAN];
    logic            ovf_r [NCHAN];

    logic              cmd_stb;
    logic [CHW-1:0]    bank_nx;
    logic [CW-1:0]     miso_cnt_nx;
    logic [AWIDTH-1:0] rd_off;
    logic [AWIDTH-1:0] wr_off;
    logic              wr_en;
    logic [CW-1:0]     data_bytes;
    logic [AWIDTH:0]   cur_len;
    logic [15:0]       cur_len16;
    logic              cur_ovf;
    logic [7:0]        rd_data;
    logic [7:0]        resp;

    // The RAM is addressed from next-state count/bank so read data lands together with the counter update.
    always_comb begin
        cmd_stb = (state == S_CMD) && user_out_stb && (mosi_cnt == '0);
        bank_nx = cmd_stb ? (user_out[CHW-1:0] & BANK_MASK) : bank_r;
        if (csn_state)
            miso_cnt_nx = '0;
        else if (user_in_ack && (miso_cnt != CNT_MAX))
            miso_cnt_nx = miso_cnt + CW'(1);
        else
            miso_cnt_nx = miso_cnt;
        rd_off     = AWIDTH'(miso_cnt_nx - CW'(2));
        wr_off     = AWIDTH'(mosi_cnt - CW'(1));
        wr_en      = ((state == S_WRITE) || (state == S_LOOP)) && user_out_stb &&
                     (mosi_cnt != '0) && (mosi_cnt <= DEPTH_C);
        data_bytes = mosi_cnt - CW'(1);
        cur_len    = len_r[bank_r];
        cur_len16  = 16'(cur_len);
        cur_ovf    = ovf_r[bank_r];
    end

    always_comb begin
        resp = 8'h00;
        if (miso_cnt == '0) begin
            resp = 8'hA5;
        end else if (miso_cnt == CW'(1)) begin
            resp = cmd_r;
        end else begin
            case (state)
                S_READ:  resp = ((miso_cnt - CW'(2)) < CW'(cur_len)) ? rd_data : 8'hFF;
                S_LOOP:  resp = loop_hold;
                S_STAT: begin
                    case (miso_cnt)
                        CW'(2):  resp = cur_len16[7:0];
                        CW'(3):  resp = cur_len16[15:8];
                        CW'(4):  resp = {7'b0, cur_ovf};
                        CW'(5):  resp = tx_cnt;
                        default: resp = 8'h00;
                    endcase
                end
                default: resp = 8'h00;
            endcase
        end
    end

    ram_sdp #(
        .DW(8),
        .AW(AWIDTH + CHW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({bank_r, wr_off}),
        .wdata (user_out),
        .re    (1'b1),
        .raddr ({bank_nx, rd_off}),
        .rdata (rd_data)
    );

    // A transaction only commits length/overflow and counts if it got past IDLE; a reset mid-transfer discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_r     <= '0;
            bank_r    <= '0;
            mosi_cnt  <= '0;
            miso_cnt  <= '0;
            loop_hold <= '0;
            tx_cnt    <= '0;
            user_in   <= 8'hA5;
            for (int i = 0; i < NCHAN; i++) begin
                len_r[i] <= '0;
                ovf_r[i] <= 1'b0;
            end
        end else begin
            user_in  <= resp;
            miso_cnt <= miso_cnt_nx;
            bank_r   <= bank_nx;
            if (csn_state)
                mosi_cnt <= '0;
            else if (user_out_stb && (mosi_cnt != CNT_MAX))
                mosi_cnt <= mosi_cnt + CW'(1);
            if (user_out_stb)
                loop_hold <= user_out;

            if (csn_rise) begin
                state <= S_IDLE;
                if ((state != S_IDLE) && (mosi_cnt != '0))
                    tx_cnt <= tx_cnt + 8'd1;
                if (((state == S_WRITE) || (state == S_LOOP)) && (mosi_cnt >= CW'(2))) begin
                    if (data_bytes > DEPTH_C) begin
                        len_r[bank_r] <= LEN_MAX;
                        ovf_r[bank_r] <= 1'b1;
                    end else begin
                        len_r[bank_r] <= data_bytes[AWIDTH:0];
                        ovf_r[bank_r] <= 1'b0;
                    end
                end
            end else begin
                case (state)
                    S_IDLE: if (csn_fall) state <= S_CMD;
                    S_CMD: begin
                        if (cmd_stb) begin
                            cmd_r <= user_out;
                            case (user_out[7:6])
                                2'b00:   state <= S_WRITE;
                                2'b01:   state <= S_READ;
                                2'b10:   state <= S_LOOP;
                                default: state <= S_STAT;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_loopback_banked.sv
// Directed bench for spi_loopback_banked (AWIDTH=4, NCHAN=4) playing the spi_dev_core side.
// Each MISO byte is checked just before the core would acknowledge it.

module tb_spi_loopback_banked;
    logic       clk;
    logic       rst_n;
    logic [7:0] user_out;
    logic       user_out_stb;
    logic [7:0] user_in;
    logic       user_in_ack;
    logic       csn_state;
    logic       csn_rise;
    logic       csn_fall;

    int compared;
    int mismatched;

    spi_loopback_banked #(
        .AWIDTH(4),
        .NCHAN (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .user_out    (user_out),
        .user_out_stb(user_out_stb),
        .user_in     (user_in),
        .user_in_ack (user_in_ack),
        .csn_state   (csn_state),
        .csn_rise    (csn_rise),
        .csn_fall    (csn_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [7:0] expected);
        compared++;
        assert (user_in === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: user_in=%02h expected=%02h", tag, user_in, expected);
        end
    endtask

    // One full byte slot: MOSI strobe, then the core consumes the current MISO byte.
    task automatic apply_stimulus(input logic [7:0] mosi);
        user_out     = mosi;
        user_out_stb = 1'b1;
        cyc(1);
        user_out_stb = 1'b0;
        cyc(1);
        user_in_ack  = 1'b1;
        cyc(1);
        user_in_ack  = 1'b0;
        cyc(4);
    endtask

    task automatic xfer(input string tag, input logic [7:0] mosi, input logic [7:0] miso);
        check_output(tag, miso);
        apply_stimulus(mosi);
    endtask

    task automatic start_txn();
        csn_state = 1'b0;
        csn_fall  = 1'b1;
        cyc(1);
        csn_fall  = 1'b0;
        cyc(3);
    endtask

    task automatic end_txn();
        csn_state = 1'b1;
        csn_rise  = 1'b1;
        cyc(1);
        csn_rise  = 1'b0;
        cyc(4);
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        rst_n        = 1'b0;
        user_out     = 8'h00;
        user_out_stb = 1'b0;
        user_in_ack  = 1'b0;
        csn_state    = 1'b1;
        csn_rise     = 1'b0;
        csn_fall     = 1'b0;
        cyc(3);
        check_output("reset_user_in", 8'hA5);
        rst_n = 1'b1;
        cyc(3);

        $display("[TB] read of empty bank 0");
        start_txn();
        xfer("rd0_b0", 8'h40, 8'hA5);
        xfer("rd0_b1", 8'h00, 8'h40);
        xfer("rd0_b2", 8'h00, 8'hFF);
        xfer("rd0_b3", 8'h00, 8'hFF);
        end_txn();

        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("[TB] write bank 1, read back, status");
        start_txn();
        xfer("wr1_b0", 8'h01, 8'hA5);
        xfer("wr1_b1", 8'h11, 8'h01);
        apply_stimulus(8'h22);
        apply_stimulus(8'h33);
        end_txn();

        start_txn();
        xfer("rd1_b0", 8'h41, 8'hA5);
        xfer("rd1_b1", 8'h00, 8'h41);
        xfer("rd1_b2", 8'h00, 8'h11);
        xfer("rd1_b3", 8'h00, 8'h22);
        xfer("rd1_b4", 8'h00, 8'h33);
        xfer("rd1_b5", 8'h00, 8'hFF);
        end_txn();

        start_txn();
        xfer("st1_b0", 8'hC1, 8'hA5);
        xfer("st1_b1", 8'h00, 8'hC1);
        xfer("st1_len_lo", 8'h00, 8'h03);
        xfer("st1_len_hi", 8'h00, 8'h00);
        xfer("st1_ovf", 8'h00, 8'h00);
        xfer("st1_txcnt", 8'h00, 8'h02);
        end_txn();

        $display("[TB] loopback into bank 2, then read it");
        start_txn();
        xfer("lp_b0", 8'h82, 8'hA5);
        xfer("lp_b1", 8'hAA, 8'h82);
        xfer("lp_b2", 8'hBB, 8'hAA);
        xfer("lp_b3", 8'hCC, 8'hBB);
        xfer("lp_b4", 8'hDD, 8'hCC);
        end_txn();

        start_txn();
        xfer("rd2_b0", 8'h42, 8'hA5);
        xfer("rd2_b1", 8'h00, 8'h42);
        xfer("rd2_b2", 8'h00, 8'hAA);
        xfer("rd2_b3", 8'h00, 8'hBB);
        xfer("rd2_b4", 8'h00, 8'hCC);
        xfer("rd2_b5", 8'h00, 8'hDD);
        end_txn();

        $display("[TB] overflow bank 0 with 20 data bytes");
        start_txn();
        xfer("wr0_b0", 8'h00, 8'hA5);
        xfer("wr0_b1", 8'h00, 8'h00);
        for (int i = 1; i < 20; i++) apply_stimulus(8'(i));
        end_txn();

        start_txn();
        xfer("st0_b0", 8'hC0, 8'hA5);
        xfer("st0_b1", 8'h00, 8'hC0);
        xfer("st0_len_lo", 8'h00, 8'h10);
        xfer("st0_len_hi", 8'h00, 8'h00);
        xfer("st0_ovf", 8'h00, 8'h01);
        xfer("st0_txcnt", 8'h00, 8'h06);
        end_txn();

        start_txn();
        xfer("rd0f_b0", 8'h40, 8'hA5);
        xfer("rd0f_b1", 8'h00, 8'h40);
        for (int i = 0; i < 16; i++) xfer($sformatf("rd0f_d%0d", i), 8'h00, 8'(i));
        xfer("rd0f_past0", 8'h00, 8'hFF);
        xfer("rd0f_past1", 8'h00, 8'hFF);
        end_txn();

        $display("[TB] short rewrite clears overflow");
        start_txn();
        xfer("wr0s_b0", 8'h00, 8'hA5);
        xfer("wr0s_b1", 8'h77, 8'h00);
        end_txn();

        start_txn();
        xfer("st0s_b0", 8'hC0, 8'hA5);
        xfer("st0s_b1", 8'h00, 8'hC0);
        xfer("st0s_len_lo", 8'h00, 8'h01);
        xfer("st0s_len_hi", 8'h00, 8'h00);
        xfer("st0s_ovf", 8'h00, 8'h00);
        xfer("st0s_txcnt", 8'h00, 8'h09);
        end_txn();

        $display("[TB] command-only abort and empty transaction");
        start_txn();
        xfer("ab_b0", 8'h03, 8'hA5);
        end_txn();
        start_txn();
        end_txn();

        start_txn();
        xfer("st3_b0", 8'hC3, 8'hA5);
        xfer("st3_b1", 8'h00, 8'hC3);
        xfer("st3_len_lo", 8'h00, 8'h00);
        xfer("st3_len_hi", 8'h00, 8'h00);
        xfer("st3_ovf", 8'h00, 8'h00);
        xfer("st3_txcnt", 8'h00, 8'h0B);
        xfer("st3_pad", 8'h00, 8'h00);
        end_txn();

        $display("[TB] reset in the middle of a write");
        start_txn();
        xfer("rw_b0", 8'h00, 8'hA5);
        xfer("rw_b1", 8'h55, 8'h00);
        rst_n = 1'b0;
        #2;
        check_output("rw_async_reset", 8'hA5);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        apply_stimulus(8'h66);
        end_txn();

        start_txn();
        xfer("rdr_b0", 8'h40, 8'hA5);
        xfer("rdr_b1", 8'h00, 8'h40);
        xfer("rdr_b2", 8'h00, 8'hFF);
        xfer("rdr_b3", 8'h00, 8'hFF);
        end_txn();

        start_txn();
        xfer("str_b0", 8'hC0, 8'hA5);
        xfer("str_b1", 8'h00, 8'hC0);
        xfer("str_len_lo", 8'h00, 8'h00);
        xfer("str_len_hi", 8'h00, 8'h00);
        xfer("str_ovf", 8'h00, 8'h00);
        xfer("str_txcnt", 8'h00, 8'h01);
        end_txn();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
